// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table capture block.
package tt_pkg;

    localparam int unsigned NUM_INPUTS   = 4;
    localparam int unsigned NUM_VECTORS  = 16;
    localparam int unsigned IDX_W        = NUM_INPUTS;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MCNT_W       = 5;
    localparam int unsigned MAX_MISMATCH = NUM_VECTORS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_FINISH
    } tt_state_t;

endpackage

// File: rtl/tt_settle_counter.sv
// Settle counter: cleared by load, advances on enable, flags the last settle cycle.
module tt_settle_counter
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all 16 input vectors through external logic and records its response.
// Optional compare against an expected table: define TT_CAPTURE_COMPARE_EN.
module truth_table_capture
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [NUM_INPUTS-1:0]  stim,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] table_out
`ifdef TT_CAPTURE_COMPARE_EN
    ,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   mismatch,
    output logic [MCNT_W-1:0]      mismatch_cnt
`endif
);

    tt_state_t        state;
    logic [IDX_W-1:0] index;
    logic             settle_load;
    logic             settle_en;
    logic             settle_tc;

    assign settle_load = (state != ST_DRIVE);
    assign settle_en   = (state == ST_DRIVE) && !settle_tc;

    tt_settle_counter #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .en   (settle_en),
        .tc   (settle_tc)
    );

`ifdef TT_CAPTURE_COMPARE_EN
    logic [NUM_VECTORS-1:0] exp_reg;
    logic [MCNT_W-1:0]      cnt_next;

    // Count as seen after the current SAMPLE, so the done-cycle flag includes vector 15.
    always_comb begin
        cnt_next = mismatch_cnt;
        if ((state == ST_SAMPLE) && (resp != exp_reg[index]) &&
            (mismatch_cnt != MCNT_W'(MAX_MISMATCH))) begin
            cnt_next = mismatch_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            index     <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
            exp_reg      <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    stim <= '0;
                    if (start) begin
                        state     <= ST_DRIVE;
                        index     <= '0;
                        busy      <= 1'b1;
                        table_out <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
                        exp_reg      <= expected;
                        mismatch     <= 1'b0;
                        mismatch_cnt <= '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (settle_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_out[index] <= resp;
`ifdef TT_CAPTURE_COMPARE_EN
                    mismatch_cnt <= cnt_next;
`endif
                    if (index == IDX_W'(NUM_VECTORS - 1)) begin
                        state <= ST_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        stim  <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
                        mismatch <= (cnt_next != '0);
`endif
                    end else begin
                        state <= ST_DRIVE;
                        index <= index + 1'b1;
                        stim  <= index + 1'b1;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
